// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: shared encodings, FSM states and flag bit positions for fpu_req_arbiter.
package fpu_arb_pkg;
  typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3} fpu_op_e;
  typedef enum logic [1:0] {RM_NEAREST = 2'd0, RM_ZERO = 2'd1, RM_UP = 2'd2, RM_DOWN = 2'd3} rmode_e;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, IDLE = 2'd2} state_e;
  localparam int FLG_SNAN = 7;
  localparam int FLG_QNAN = 6;
  localparam int FLG_INF  = 5;
  localparam int FLG_INE  = 4;
  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_DBZ  = 1;
  localparam int FLG_ZERO = 0;
  localparam logic [7:0] EXC_MASK = 8'b1100_1110;
  function automatic logic is_exc(input logic [7:0] flags);
    return |(flags & EXC_MASK);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting at a pointer that advances past each winner.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [W-1:0] ptr_q, ptr_d, j;
  // Scan from furthest offset down so the closest requester at/after ptr wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr_q) + i) % N);
      if (en_i && req_i[j]) begin
        idx_o = j;
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
    ptr_d = any_o ? ((idx_o == W'(N - 1)) ? '0 : idx_o + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one fixed-latency pipelined fpu core among NUM_REQ requesters.
// Optional FPU_ARB_STATS_EN adds saturating issue/exception counters.
module fpu_req_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 4,
  localparam int TAG_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*3-1:0]  req_op,
  input  logic [NUM_REQ*2-1:0]  req_rmode,
  input  logic [NUM_REQ*32-1:0] req_opa,
  input  logic [NUM_REQ*32-1:0] req_opb,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [7:0]            rsp_flags,
  input  logic                  flush,
  output logic                  busy,
  output logic [2:0]            fpu_op,
  output logic [1:0]            fpu_rmode,
  output logic [31:0]           fpu_opa,
  output logic [31:0]           fpu_opb,
`ifdef FPU_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0] stat_issued,
  output logic [15:0]           stat_exc,
`endif
  input  logic [31:0]           fpu_out,
  input  logic [7:0]            fpu_flags
);
  state_e state_q, state_d;
  logic [TAG_W-1:0] gidx, pend_t_q;
  logic xfer, pend_v_q, inflight;
  logic [2:0] op_q;
  logic [1:0] rmode_q;
  logic [31:0] opa_q, opb_q, rsp_data_q;
  logic [7:0] rsp_flags_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [FPU_LAT-1:0] pv_q;
  logic [FPU_LAT*TAG_W-1:0] pt_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == RUN),
    .req_i (req_valid),
    .gnt_o (req_ready),
    .idx_o (gidx),
    .any_o (xfer)
  );

  // pend_* holds the op whose core result is on fpu_out this cycle.
  assign inflight  = |pv_q || pend_v_q;
  assign busy      = (state_q != RUN) || inflight;
  assign fpu_op    = op_q;
  assign fpu_rmode = rmode_q;
  assign fpu_opa   = opa_q;
  assign fpu_opb   = opb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;

  always_comb begin
    state_d = state_q;
    state_d = (state_q == RUN) ? (flush ? DRAIN : RUN) :
              (state_q == DRAIN) ? (inflight ? DRAIN : IDLE) : RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      op_q        <= '0;
      rmode_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      pv_q        <= '0;
      pt_q        <= '0;
      pend_v_q    <= 1'b0;
      pend_t_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        op_q    <= req_op[3*gidx +: 3];
        rmode_q <= req_rmode[2*gidx +: 2];
        opa_q   <= req_opa[32*gidx +: 32];
        opb_q   <= req_opb[32*gidx +: 32];
      end
      pv_q        <= {pv_q[FPU_LAT-2:0], xfer};
      pt_q        <= {pt_q[(FPU_LAT-1)*TAG_W-1:0], gidx};
      pend_v_q    <= pv_q[FPU_LAT-1];
      pend_t_q    <= pt_q[FPU_LAT*TAG_W-1 -: TAG_W];
      rsp_valid_q <= pend_v_q ? (NUM_REQ'(1) << pend_t_q) : '0;
      if (pend_v_q) begin
        rsp_data_q  <= fpu_out;
        rsp_flags_q <= fpu_flags;
      end
    end
  end

`ifdef FPU_ARB_STATS_EN
  logic [15:0] iss_q [NUM_REQ];
  logic [15:0] exc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) iss_q[i] <= '0;
      exc_q <= '0;
    end else begin
      if (xfer && iss_q[gidx] != 16'hFFFF) iss_q[gidx] <= iss_q[gidx] + 16'd1;
      if (pend_v_q && is_exc(fpu_flags) && exc_q != 16'hFFFF) exc_q <= exc_q + 16'd1;
    end
  end
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_issued[16*g +: 16] = iss_q[g];
  end
  assign stat_exc = exc_q;
`endif
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter: directed checks of arbitration, latency, flush, exceptions and reset.
// A behavioural core stub stands in for the fpu with the same fixed latency.
module tb_fpu_req_arbiter;
  import fpu_arb_pkg::*;
  localparam int N = 4;
  localparam int LAT = 4;
  localparam logic [31:0] CA [4] = '{32'h1000_0011, 32'h2000_0022, 32'h3000_0033, 32'h4000_0044};
  localparam logic [31:0] CB [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400};
  localparam logic [31:0] ER [4] = '{32'h1000_0111, 32'h2000_0223, 32'h3000_0335, 32'h4000_0447};
  localparam logic [7:0]  EF [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, busy;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid;
  logic [N*3-1:0] req_op = '0;
  logic [N*2-1:0] req_rmode = '0;
  logic [N*32-1:0] req_opa = '0, req_opb = '0;
  logic [31:0] rsp_data, fpu_opa, fpu_opb, fpu_out;
  logic [7:0] rsp_flags, fpu_flags;
  logic [2:0] fpu_op;
  logic [1:0] fpu_rmode;
`ifdef FPU_ARB_STATS_EN
  logic [N*16-1:0] stat_issued;
  logic [15:0] stat_exc;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fpu_req_arbiter #(.NUM_REQ(N), .FPU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rmode(req_rmode), .req_opa(req_opa), .req_opb(req_opb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .flush(flush), .busy(busy), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
`ifdef FPU_ARB_STATS_EN
    .stat_issued(stat_issued), .stat_exc(stat_exc),
`endif
    .fpu_out(fpu_out), .fpu_flags(fpu_flags)
  );

  // Core stub: known answers for the two IEEE cases, otherwise a traceable mix of the inputs.
  function automatic logic [39:0] core_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD && a == 32'h41C0_0000 && b == 32'h4080_0000) return {32'h41E0_0000, 8'h00};
    if (op == OP_DIV && b == 32'h0) return {32'h7F80_0000, 8'h22};
    return {a + b + 32'(op), a[7:0]};
  endfunction
  logic [31:0] cq [LAT];
  logic [7:0]  cf [LAT];
  always @(posedge clk) begin
    {cq[0], cf[0]} <= core_f(fpu_op, fpu_opa, fpu_opb);
    for (int i = 1; i < LAT; i++) begin
      cq[i] <= cq[i-1];
      cf[i] <= cf[i-1];
    end
  end
  assign fpu_out   = cq[LAT-1];
  assign fpu_flags = cf[LAT-1];

  task automatic set_req(input int r, input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a, input logic [31:0] b);
    req_op[3*r +: 3]     = op;
    req_rmode[2*r +: 2]  = rm;
    req_opa[32*r +: 32]  = a;
    req_opb[32*r +: 32]  = b;
  endtask

  task automatic load_table();
    for (int r = 0; r < N; r++) set_req(r, 3'(r), 2'(r), CA[r], CB[r]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({fpu_op, fpu_rmode, fpu_opa, fpu_opb, rsp_flags} !== '0) begin bad++; $display("FAIL reset_core_regs got op=%h rm=%h a=%h b=%h fl=%h want 0", fpu_op, fpu_rmode, fpu_opa, fpu_opb, rsp_flags); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      if (n == 0) begin
        set_req(0, OP_ADD, RM_UP, 32'h41C0_0000, 32'h4080_0000);
        req_valid = 4'b0001;
      end
      if (n == 1) req_valid = 4'b0000;
      #1;
      if (n == 0) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
      end
      if (n == 1) begin
        total++; if (fpu_opa !== 32'h41C0_0000 || fpu_opb !== 32'h4080_0000 || fpu_op !== 3'd0 || fpu_rmode !== 2'd2) begin
          bad++; $display("FAIL single_core_in got op=%h rm=%h a=%h b=%h want 0/2/41c00000/40800000", fpu_op, fpu_rmode, fpu_opa, fpu_opb); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
      end
      total++; if (rsp_valid !== ((n == 6) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL single_rsp_valid n=%0d got=%b want=%b", n, rsp_valid, (n == 6) ? 4'b0001 : 4'b0000); end
      if (n == 6) begin
        total++; if (rsp_data !== 32'h41E0_0000) begin bad++; $display("FAIL single_data got=%h want=41e00000", rsp_data); end
        total++; if (rsp_flags[FLG_ZERO] !== 1'b0 || rsp_flags !== 8'h00) begin bad++; $display("FAIL single_flags got=%h want=00", rsp_flags); end
      end
      if (n == 8) begin
        total++; if (busy !== 1'b0 || rsp_data !== 32'h41E0_0000) begin bad++; $display("FAIL single_hold got busy=%b data=%h want 0/41e00000", busy, rsp_data); end
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] e;
    do_reset();
    load_table();
    for (int n = 0; n <= 15; n++) begin
      @(negedge clk);
      req_valid = (n < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (n < 8) begin
        e = 4'b0001 << (n % 4);
        total++; if (req_ready !== e) begin bad++; $display("FAIL cont_grant n=%0d got=%b want=%b", n, req_ready, e); end
      end
      if (n >= 6 && n <= 13) begin
        e = 4'b0001 << ((n - 6) % 4);
        total++; if (rsp_valid !== e || rsp_data !== ER[(n-6)%4] || rsp_flags !== EF[(n-6)%4]) begin
          bad++; $display("FAIL cont_rsp n=%0d got v=%b d=%h f=%h want v=%b d=%h f=%h", n, rsp_valid, rsp_data, rsp_flags, e, ER[(n-6)%4], EF[(n-6)%4]); end
      end else begin
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL cont_idle n=%0d got=%b want=0000", n, rsp_valid); end
      end
    end
`ifdef FPU_ARB_STATS_EN
    total++; if (stat_issued !== {4{16'd2}}) begin bad++; $display("FAIL cont_stat got=%h want=0002000200020002", stat_issued); end
`endif
  endtask

  task automatic test_wrap();
    localparam logic [3:0] WV [12] = '{4'b0100, 4'b0000, 4'b1010, 4'b0010, 4'b1101, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    localparam logic [3:0] WR [12] = '{4'b0100, 4'b0000, 4'b1000, 4'b0010, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    localparam logic [3:0] WS [12] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b0, 4'b1000, 4'b0010, 4'b0100, 4'b0};
    logic [3:0] e;
    do_reset();
    load_table();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      req_valid = WV[n];
      #1;
      e = WR[n];
      total++; if (req_ready !== e) begin bad++; $display("FAIL wrap_grant n=%0d got=%b want=%b", n, req_ready, e); end
      e = WS[n];
      total++; if (rsp_valid !== e) begin bad++; $display("FAIL wrap_rsp n=%0d got=%b want=%b", n, rsp_valid, e); end
      for (int r = 0; r < N; r++)
        if (e[r]) begin
          total++; if (rsp_data !== ER[r]) begin bad++; $display("FAIL wrap_data n=%0d got=%h want=%h", n, rsp_data, ER[r]); end
        end
    end
  endtask

  task automatic test_flush();
    logic [3:0] e;
    do_reset();
    set_req(0, OP_MUL, RM_ZERO, CA[2], CB[2]);
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      flush = (n == 2 || n == 5);
      #1;
      e = (n <= 2 || n == 10) ? 4'b0001 : 4'b0000;
      total++; if (req_ready !== e) begin bad++; $display("FAIL flush_ready n=%0d got=%b want=%b", n, req_ready, e); end
      total++; if (busy !== (n >= 1 && n <= 9)) begin bad++; $display("FAIL flush_busy n=%0d got=%b want=%b", n, busy, (n >= 1 && n <= 9)); end
      e = (n >= 6 && n <= 8) ? 4'b0001 : 4'b0000;
      total++; if (rsp_valid !== e) begin bad++; $display("FAIL flush_rsp n=%0d got=%b want=%b", n, rsp_valid, e); end
    end
    req_valid = 4'b0000;
    flush = 1'b0;
  endtask

  task automatic test_exc();
    do_reset();
    set_req(1, OP_DIV, RM_NEAREST, 32'h3F80_0000, 32'h0000_0000);
    for (int n = 0; n <= 7; n++) begin
      @(negedge clk);
      req_valid = (n == 0) ? 4'b0010 : 4'b0000;
      #1;
      if (n == 0) begin
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL exc_ready got=%b want=0010", req_ready); end
      end
      if (n == 6) begin
        total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL exc_rsp_valid got=%b want=0010", rsp_valid); end
        total++; if (rsp_data !== 32'h7F80_0000) begin bad++; $display("FAIL exc_data got=%h want=7f800000", rsp_data); end
        total++; if (rsp_flags[FLG_DBZ] !== 1'b1 || rsp_flags[FLG_INF] !== 1'b1 || rsp_flags !== 8'h22) begin bad++; $display("FAIL exc_flags got=%h want=22", rsp_flags); end
      end
    end
`ifdef FPU_ARB_STATS_EN
    total++; if (stat_exc !== 16'd1) begin bad++; $display("FAIL exc_stat got=%0d want=1", stat_exc); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    load_table();
    for (int n = 0; n <= 14; n++) begin
      @(negedge clk);
      req_valid = (n < 3) ? 4'b0111 : 4'b0000;
      if (n == 5) rst_n = 1'b1;
      #1;
      if (n < 3) begin
        e = (n == 0) ? 4'b0100 : (n == 1) ? 4'b0001 : 4'b0010;
        total++; if (req_ready !== e) begin bad++; $display("FAIL mid_grant n=%0d got=%b want=%b", n, req_ready, e); end
      end
      if (n == 3) begin
        total++; if (busy !== 1'b1 || rsp_data !== 32'h7F80_0000) begin bad++; $display("FAIL mid_pre got busy=%b data=%h want 1/7f800000", busy, rsp_data); end
        rst_n = 1'b0;
        #1;
        total++; if (rsp_data !== 32'h0 || rsp_flags !== 8'h0) begin bad++; $display("FAIL mid_rsp_clear got d=%h f=%h want 0", rsp_data, rsp_flags); end
        total++; if (busy !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("FAIL mid_ctrl_clear got busy=%b ready=%b want 0", busy, req_ready); end
        total++; if ({fpu_op, fpu_rmode, fpu_opa, fpu_opb} !== '0) begin bad++; $display("FAIL mid_core_clear got op=%h a=%h b=%h want 0", fpu_op, fpu_opa, fpu_opb); end
      end
      if (n >= 3) begin
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL mid_no_rsp n=%0d got=%b want=0000", n, rsp_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_flush();
    test_exc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
